// File: rtl/cpu_pkg.sv
// Shared types and widths for the fetch front end.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HALT
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int IMM_W       = 16;
    localparam int JIDX_W      = 26;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats fall-through.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0]       pc,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [31:0]       next_pc,
    output logic [31:0]       pc_plus4
);

    logic [31:0] w_branchOffset;
    logic [31:0] w_branchTarget;
    logic [31:0] w_jumpTarget;

    assign pc_plus4 = pc + 32'(INSTR_BYTES);

    // Immediate is a word offset relative to the following instruction.
    assign w_branchOffset = {{(32-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};
    assign w_branchTarget = pc_plus4 + w_branchOffset;
    assign w_jumpTarget   = {pc_plus4[31:28], jump_index, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = w_jumpTarget;
        end else if (branch_taken) begin
            next_pc = w_branchTarget;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding the instruction memory.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] PROG_BYTES = 32'd80,
    parameter int          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4,
    output logic              imem_load,
    output logic              fetch_valid,
    output logic              done,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic             r_imemLoad;
    logic             r_fetchValid;
    logic             r_done;
    logic [CNT_W-1:0] r_instrCount;
    logic [31:0]      w_nextPc;
    logic [31:0]      w_pcPlus4;

    next_pc_calc u_nextPc (
        .pc           (r_pc),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .next_pc      (w_nextPc),
        .pc_plus4     (w_pcPlus4)
    );

    // All flags are registered alongside the state so they change only on the clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_imemLoad   <= 1'b0;
            r_fetchValid <= 1'b0;
            r_done       <= 1'b0;
            r_instrCount <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_state      <= LOAD;
                        r_pc         <= RESET_PC;
                        r_imemLoad   <= 1'b1;
                        r_fetchValid <= 1'b0;
                        r_done       <= 1'b0;
                        r_instrCount <= '0;
                    end
                end
                LOAD: begin
                    r_state      <= RUN;
                    r_imemLoad   <= 1'b0;
                    r_fetchValid <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (r_instrCount != {CNT_W{1'b1}}) begin
                            r_instrCount <= r_instrCount + CNT_ONE;
                        end
                        // Leaving the image halts with the PC parked on the last fetched word.
                        if (w_nextPc >= PROG_BYTES) begin
                            r_state      <= HALT;
                            r_fetchValid <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_pc <= w_nextPc;
                        end
                    end
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign pc_plus4    = w_pcPlus4;
    assign imem_load   = r_imemLoad;
    assign fetch_valid = r_fetchValid;
    assign done        = r_done;
    assign instr_count = r_instrCount;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised scoreboard bench for pc_fetch_unit against a behavioural fetch model.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] count;
        logic        load;
        logic        valid;
        logic        done;
        int          stepId;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        imem_load;
    logic        fetch_valid;
    logic        done;
    logic [15:0] instr_count;

    exp_t        expQ[$];
    int          nChecks = 0;
    int          nPass = 0;
    int          stepNo = 0;

    logic [31:0] mPc = 32'h0;
    int unsigned mCount = 0;
    bit          mLoading = 1'b0;
    bit          mRunning = 1'b0;
    bit          mHalted = 1'b0;

    pc_fetch_unit #(
        .RESET_PC   (32'h0),
        .PROG_BYTES (32'd80),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .imem_load    (imem_load),
        .fetch_valid  (fetch_valid),
        .done         (done),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] targetOf(input logic [31:0] pc, input bit br,
                                             input logic [15:0] imm, input bit jmp,
                                             input logic [25:0] jidx);
        logic [31:0] p4;
        logic signed [15:0] sImm;
        int off;
        p4 = pc + 32'd4;
        if (jmp) return (p4 & 32'hF000_0000) | (32'(jidx) * 32'd4);
        if (br) begin
            sImm = imm;
            off = int'(sImm) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic modelStep(input bit r, input bit s, input bit st, input bit br,
                             input logic [15:0] imm, input bit j, input logic [25:0] ji);
        logic [31:0] t;
        if (!r) begin
            mPc = 32'h0; mCount = 0;
            mLoading = 0; mRunning = 0; mHalted = 0;
        end else if (mLoading) begin
            mLoading = 0; mRunning = 1;
        end else if (mRunning) begin
            if (!st) begin
                if (mCount < 65535) mCount++;
                t = targetOf(mPc, br, imm, j, ji);
                if (t >= 32'd80) begin
                    mRunning = 0; mHalted = 1;
                end else begin
                    mPc = t;
                end
            end
        end else if (s) begin
            mLoading = 1; mHalted = 0; mPc = 32'h0; mCount = 0;
        end
    endtask

    // Inputs change on the falling edge; the expected post-edge snapshot is queued immediately.
    task automatic applyStimulus(input bit r, input bit s, input bit st, input bit br,
                                 input logic [15:0] imm, input bit j, input logic [25:0] ji);
        exp_t e;
        @(negedge clk);
        rst_n = r; start = s; stall = st;
        branch_taken = br; branch_imm = imm; jump = j; jump_index = ji;
        modelStep(r, s, st, br, imm, j, ji);
        e.pc = mPc; e.count = 16'(mCount);
        e.load = mLoading; e.valid = mRunning; e.done = mHalted;
        e.stepId = stepNo++;
        expQ.push_back(e);
    endtask

    task automatic idleStep();
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 26'h0);
    endtask

    task automatic checkOne(input string name, input int stepId,
                            input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("[TB] FAIL %s step %0d: got %h, expected %h", name, stepId, got, want);
    endtask

    task automatic checkOutput(input exp_t e);
        checkOne("pc_out",      e.stepId, pc_out, e.pc);
        checkOne("pc_plus4",    e.stepId, pc_plus4, e.pc + 32'd4);
        checkOne("imem_load",   e.stepId, 32'(imem_load), 32'(e.load));
        checkOne("fetch_valid", e.stepId, 32'(fetch_valid), 32'(e.valid));
        checkOne("done",        e.stepId, 32'(done), 32'(e.done));
        checkOne("instr_count", e.stepId, 32'(instr_count), 32'(e.count));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit r, s, st, br, j;
        logic [15:0] imm;
        logic [25:0] ji;

        applyStimulus(0, 0, 0, 0, 16'h0, 0, 26'h0);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 26'h0);
        applyStimulus(1, 1, 0, 0, 16'h0, 0, 26'h0);
        idleStep();
        for (int i = 0; i < 40 && !mHalted; i++) idleStep();
        idleStep();

        // Restart from HALT and walk the branch / jump / stall corner cases.
        applyStimulus(1, 1, 0, 0, 16'h0, 0, 26'h0);
        idleStep();
        idleStep();
        idleStep();
        applyStimulus(1, 0, 0, 1, 16'hFFFE, 0, 26'h0);
        applyStimulus(1, 0, 0, 1, 16'h0003, 0, 26'h0);
        applyStimulus(1, 0, 0, 1, 16'hFFFD, 0, 26'h0);
        applyStimulus(1, 0, 0, 1, 16'h0001, 1, 26'h4);
        applyStimulus(1, 0, 0, 1, 16'hFFFE, 0, 26'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, 16'h0001, 0, 26'h0);
        idleStep();
        applyStimulus(1, 0, 0, 1, 16'h0001, 0, 26'h0);
        for (int i = 0; i < 20 && mPc != 32'd40; i++) idleStep();
        applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0);
        idleStep();

        applyStimulus(1, 1, 0, 0, 16'h0, 0, 26'h0);
        idleStep();
        applyStimulus(1, 0, 0, 1, 16'd63, 0, 26'h0);
        idleStep();
        applyStimulus(1, 1, 0, 0, 16'h0, 0, 26'h0);
        idleStep();

        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) >= 2);
            s   = ($urandom_range(0, 99) < 30);
            st  = ($urandom_range(0, 99) < 25);
            br  = ($urandom_range(0, 99) < 20);
            j   = ($urandom_range(0, 99) < 5);
            imm = 16'($urandom_range(0, 16)) - 16'd8;
            ji  = 26'($urandom_range(0, 24));
            if ($urandom_range(0, 99) < 3) ji = 26'($urandom);
            applyStimulus(r, s, st, br, imm, j, ji);
        end

        repeat (3) @(posedge clk);
        #2;
        checkOne("drain", stepNo, 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
